// File: rtl/noc_flit_pkg.sv
// rtl/noc_flit_pkg.sv - flit types, field layout and packet limits for the local packetizer
//
// Shared by noc_local_packetizer and flit_parity.
// Flit layout (32 bits):
//   header    : [31:29] type, [28:17] flit count, [16:13] dst, [12:9] src, [8:1] id, [0] parity
//   body/tail : [31:29] type, [28:1] payload, [0] parity
package noc_flit_pkg;

    localparam int FLIT_W   = 32;

    localparam int TYPE_LSB = 29;
    localparam int TYPE_W   = 3;
    localparam int LEN_LSB  = 17;
    localparam int LEN_W    = 12;
    localparam int DST_LSB  = 13;
    localparam int DST_W    = 4;
    localparam int SRC_LSB  = 9;
    localparam int SRC_W    = 4;
    localparam int ID_LSB   = 1;
    localparam int ID_W     = 8;
    localparam int PAY_LSB  = 1;
    localparam int PAY_W    = 28;

    localparam logic [TYPE_W-1:0] FLIT_TYPE_HDR  = 3'b001;
    localparam logic [TYPE_W-1:0] FLIT_TYPE_BODY = 3'b010;
    localparam logic [TYPE_W-1:0] FLIT_TYPE_TAIL = 3'b100;

    // Largest payload whose total flit count (payload + header) still fits LEN_W bits.
    localparam int MAX_PAYLOAD = 4094;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_TAIL = 2'd3
    } pkt_state_e;

    // Upper 31 bits of a header flit; bit 0 (parity) is appended on load.
    function automatic logic [FLIT_W-1:1] hdr_bits(input logic [LEN_W-1:0] flit_cnt,
                                                   input logic [DST_W-1:0] dst,
                                                   input logic [SRC_W-1:0] src,
                                                   input logic [ID_W-1:0]  id);
        return {FLIT_TYPE_HDR, flit_cnt, dst, src, id};
    endfunction

    // Upper 31 bits of a body or tail flit.
    function automatic logic [FLIT_W-1:1] pay_bits(input logic [TYPE_W-1:0] ftype,
                                                   input logic [PAY_W-1:0]  pay);
        return {ftype, pay};
    endfunction

endpackage

// File: rtl/flit_parity.sv
// rtl/flit_parity.sv - even-parity bit over flit bits [31:1]
//
// Only present when NOC_FLIT_PARITY_EN is defined.
// Ports:
//   bits_i   in  31  flit bits [31:1] being loaded
//   parity_o out 1   value for bit [0] so the whole flit has even parity
`ifdef NOC_FLIT_PARITY_EN
module flit_parity
    import noc_flit_pkg::*;
(
    input  logic [FLIT_W-1:1] bits_i,
    output logic              parity_o
);

    assign parity_o = ^bits_i;

endmodule
`endif

// File: rtl/noc_local_packetizer.sv
// rtl/noc_local_packetizer.sv - local-port transmit packetizer: request + payload stream to header/body/tail flits
//
// Optional feature macro: NOC_FLIT_PARITY_EN (even parity in flit bit 0; bit 0 = 0 when undefined).
// Ports:
//   clk, rst_active_low           clock, asynchronous active-low reset
//   pkt_valid/pkt_ready           packet request handshake, with pkt_dst (4) and pkt_len (12)
//   pay_valid/pay_ready/pay_data  payload word stream (28-bit words)
//   tx_data/tx_rts/tx_cts         flit output to router L_RX / L_DRTS, backpressure from L_CTS
//   busy                          high whenever not idle
//   pkt_done                      pulse on the cycle the tail flit transfers
//   err_len                       pulse on the cycle an illegal-length request is dropped
module noc_local_packetizer
    import noc_flit_pkg::*;
#(
    parameter logic [SRC_W-1:0] CUR_ADDR   = 4'b0011,
    parameter int               DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_active_low,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [DST_W-1:0]      pkt_dst,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic                  pay_valid,
    output logic                  pay_ready,
    input  logic [PAY_W-1:0]      pay_data,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_rts,
    input  logic                  tx_cts,
    output logic                  busy,
    output logic                  pkt_done,
    output logic                  err_len
);

    pkt_state_e            state_q, state_d;
    logic                  ready_en_q;
    logic [ID_W-1:0]       id_q, id_d;
    logic [LEN_W-1:0]      rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rts_q, rts_d;

    logic                  load_en;
    logic [FLIT_W-1:1]     load_hi;
    logic                  par;
    logic                  xfer;
    logic                  len_legal;

    assign xfer      = rts_q && tx_cts;
    assign len_legal = (pkt_len != '0) && (pkt_len <= LEN_W'(MAX_PAYLOAD));

`ifdef NOC_FLIT_PARITY_EN
    flit_parity u_parity (
        .bits_i   (load_hi),
        .parity_o (par)
    );
`else
    assign par = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        rem_d     = rem_q;
        rts_d     = rts_q;
        load_en   = 1'b0;
        load_hi   = '0;
        pkt_ready = 1'b0;
        pay_ready = 1'b0;
        pkt_done  = 1'b0;
        err_len   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ready_en_q holds pkt_ready low for the first cycle out of reset.
                pkt_ready = ready_en_q;
                if (pkt_valid && ready_en_q) begin
                    if (len_legal) begin
                        load_en = 1'b1;
                        load_hi = hdr_bits(pkt_len + LEN_W'(1), pkt_dst, CUR_ADDR, id_q);
                        rts_d   = 1'b1;
                        id_d    = id_q + ID_W'(1);
                        rem_d   = pkt_len;
                        state_d = ST_HDR;
                    end else begin
                        err_len = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    rts_d   = 1'b0;
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                // Register can take a word when empty or when it empties this cycle.
                pay_ready = !rts_q || tx_cts;
                if (pay_valid && pay_ready) begin
                    load_en = 1'b1;
                    rts_d   = 1'b1;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        load_hi = pay_bits(FLIT_TYPE_TAIL, pay_data);
                        state_d = ST_TAIL;
                    end else begin
                        load_hi = pay_bits(FLIT_TYPE_BODY, pay_data);
                    end
                end else if (xfer) begin
                    // Starved: drop rts rather than emit a bubble flit.
                    rts_d = 1'b0;
                end
            end
            ST_TAIL: begin
                if (xfer) begin
                    rts_d    = 1'b0;
                    pkt_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                rts_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        data_d = load_en ? {load_hi, par} : data_q;
    end

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            state_q    <= ST_IDLE;
            ready_en_q <= 1'b0;
            id_q       <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            rts_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;
            id_q       <= id_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            rts_q      <= rts_d;
        end
    end

    assign tx_data = data_q;
    assign tx_rts  = rts_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_noc_local_packetizer.sv
// tb/tb_noc_local_packetizer.sv - self-checking bench for noc_local_packetizer
module tb_noc_local_packetizer;

    logic        clk;
    logic        rst_active_low;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [3:0]  pkt_dst;
    logic [11:0] pkt_len;
    logic        pay_valid;
    logic        pay_ready;
    logic [27:0] pay_data;
    logic [31:0] tx_data;
    logic        tx_rts;
    logic        tx_cts;
    logic        busy;
    logic        pkt_done;
    logic        err_len;

    int total = 0;
    int bad   = 0;

    logic [31:0] flits[$];
    int          done_cnt;
    int          err_cnt;
    bit          hold_v = 0;
    logic [31:0] hold_d = '0;
    bit          saw_drop;

    noc_local_packetizer #(.CUR_ADDR(4'b0011), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_active_low (rst_active_low),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .pkt_dst        (pkt_dst),
        .pkt_len        (pkt_len),
        .pay_valid      (pay_valid),
        .pay_ready      (pay_ready),
        .pay_data       (pay_data),
        .tx_data        (tx_data),
        .tx_rts         (tx_rts),
        .tx_cts         (tx_cts),
        .busy           (busy),
        .pkt_done       (pkt_done),
        .err_len        (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] with_par(input logic [31:0] w);
`ifdef NOC_FLIT_PARITY_EN
        return {w[31:1], ^w[31:1]};
`else
        return {w[31:1], 1'b0};
`endif
    endfunction

    function automatic logic [27:0] pay_word(input int vi, input int k);
        logic [27:0] w;
        if (vi == 2) begin
            case (k)
                0:       w = 28'hAAAAAAA;
                1:       w = 28'h1234567;
                default: w = 28'h0FFFFFF;
            endcase
        end else begin
            w = 28'(32'h05A5A5A + k * 32'h0013579 + vi * 32'h0710000);
        end
        return w;
    endfunction

    // Flit capture, hold-stability and pay_ready-under-stall checks.
    always @(negedge clk) begin
        if (hold_v) begin
            total++;
            if (!(tx_rts === 1'b1 && tx_data === hold_d)) begin
                bad++;
                $display("FAIL hold_stable: got rts=%b data=%h expected rts=1 data=%h", tx_rts, tx_data, hold_d);
            end
        end
        hold_v = rst_active_low && tx_rts && !tx_cts;
        hold_d = tx_data;
        if (rst_active_low && tx_rts && !tx_cts) begin
            total++;
            if (pay_ready !== 1'b0) begin
                bad++;
                $display("FAIL pay_ready_stall: got %b expected 0", pay_ready);
            end
        end
        if (rst_active_low && tx_rts && tx_cts) flits.push_back(tx_data);
        if (pkt_done) done_cnt++;
        if (err_len)  err_cnt++;
    end

    task automatic run_pkt(input int vi, input logic [3:0] dst, input logic [11:0] len,
                           input int cts_mode, input int starve_at);
        int k, cyc, starve_left;
        bit acc, fin, hs_pkt, hs_pay, dn, er;
        k = 0; cyc = 0; starve_left = 3; acc = 0; fin = 0;
        flits.delete();
        done_cnt = 0; err_cnt = 0; saw_drop = 0;
        pkt_valid = 1'b1; pkt_dst = dst; pkt_len = len; pay_valid = 1'b0;
        while (!fin) begin
            tx_cts = (cts_mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (acc && k == starve_at && starve_left > 0) begin
                pay_valid = 1'b0;
                starve_left--;
            end else begin
                pay_valid = acc && (k < int'(len));
            end
            pay_data = pay_word(vi, k);
            @(negedge clk);
            hs_pkt = pkt_valid && pkt_ready;
            hs_pay = pay_valid && pay_ready;
            dn = pkt_done;
            er = err_len;
            if (starve_left < 3 && busy && !tx_rts) saw_drop = 1;
            @(posedge clk);
            #1;
            if (hs_pkt) begin
                pkt_valid = 1'b0;
                acc = 1;
            end
            if (hs_pay) k++;
            if (dn || er) fin = 1;
            cyc++;
            if (cyc > 20000) begin
                total++; bad++;
                $display("FAIL timeout: got no completion after %0d cycles expected pkt_done or err_len", cyc);
                fin = 1;
            end
        end
        pkt_valid = 1'b0;
        pay_valid = 1'b0;
        tx_cts    = 1'b1;
    endtask

    task automatic check_legal(input int vi, input logic [11:0] len, input logic [31:0] exp_hdr);
        int nbad, first;
        logic [31:0] exp;
        chk("err_cnt", 32'(err_cnt), 32'd0);
        chk("done_cnt", 32'(done_cnt), 32'd1);
        chk("flit_count", 32'(flits.size()), 32'(len) + 32'd1);
        chk("header", (flits.size() > 0) ? flits[0] : 32'hDEADBEEF, with_par(exp_hdr));
        nbad = 0; first = -1;
        for (int i = 1; i < flits.size(); i++) begin
            exp = with_par({(i == int'(len)) ? 3'b100 : 3'b010, pay_word(vi, i - 1), 1'b0});
            if (flits[i] !== exp) begin
                nbad++;
                if (first < 0) first = i;
            end
        end
        if (nbad != 0) $display("note: first bad payload flit index %0d", first);
        chk("payload_flits_bad", 32'(nbad), 32'd0);
    endtask

    task automatic do_reset();
        rst_active_low = 1'b0;
        pkt_valid = 1'b0; pay_valid = 1'b0; tx_cts = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_active_low = 1'b1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  dst;
        logic [11:0] len;
        int          cts_mode;
        int          starve_at;
        bit          exp_err;
        logic [31:0] exp_hdr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // Headers hand-assembled from the field layout, parity bit left 0.
        vecs[0] = '{4'h1, 12'd0,    0, -1, 1'b1, 32'h0};
        vecs[1] = '{4'h1, 12'd4095, 0, -1, 1'b1, 32'h0};
        vecs[2] = '{4'h1, 12'd3,    0, -1, 1'b0, 32'h20082600};
        vecs[3] = '{4'h5, 12'd4,    1, -1, 1'b0, 32'h200AA602};
        vecs[4] = '{4'hF, 12'd5,    0,  2, 1'b0, 32'h200DE604};
        vecs[5] = '{4'h2, 12'd1,    1, -1, 1'b0, 32'h20044606};
        vecs[6] = '{4'hA, 12'd4094, 0, -1, 1'b0, 32'h3FFF4608};

        rst_active_low = 1'b0;
        pkt_valid = 1'b0; pkt_dst = '0; pkt_len = '0;
        pay_valid = 1'b0; pay_data = '0; tx_cts = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_data",   tx_data, 32'h0);
        chk("rst_tx_rts",    32'(tx_rts), 32'd0);
        chk("rst_pkt_ready", 32'(pkt_ready), 32'd0);
        chk("rst_pay_ready", 32'(pay_ready), 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_pkt_done",  32'(pkt_done), 32'd0);
        chk("rst_err_len",   32'(err_len), 32'd0);
        rst_active_low = 1'b1;
        @(negedge clk);
        chk("pkt_ready_first_cycle", 32'(pkt_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("pkt_ready_after_cycle", 32'(pkt_ready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            run_pkt(v, vecs[v].dst, vecs[v].len, vecs[v].cts_mode, vecs[v].starve_at);
            if (vecs[v].exp_err) begin
                chk("err_pulse", 32'(err_cnt), 32'd1);
                chk("err_no_flits", 32'(flits.size()), 32'd0);
                chk("err_rts_low", 32'(tx_rts), 32'd0);
                chk("err_not_busy", 32'(busy), 32'd0);
            end else begin
                check_legal(v, vecs[v].len, vecs[v].exp_hdr);
            end
            if (vecs[v].starve_at >= 0) chk("starve_rts_drop", 32'(saw_drop), 32'd1);
        end

        // Id wrap: 257 single-word packets from a fresh reset.
        do_reset();
        for (int p = 0; p < 257; p++) begin
            run_pkt(10, 4'h7, 12'd1, 0, -1);
            check_legal(10, 12'd1, 32'h2004E600 | (32'(p % 256) << 1));
        end

        // Reset in the middle of the body.
        @(posedge clk);
        #1;
        pkt_valid = 1'b1; pkt_dst = 4'h4; pkt_len = 12'd6;
        pay_valid = 1'b1; pay_data = 28'h1111111; tx_cts = 1'b1;
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("mid_busy_before", 32'(busy), 32'd1);
        chk("mid_rts_before", 32'(tx_rts), 32'd1);
        rst_active_low = 1'b0;
        #1;
        chk("mid_rts_async", 32'(tx_rts), 32'd0);
        chk("mid_busy_async", 32'(busy), 32'd0);
        chk("mid_data_async", tx_data, 32'h0);
        chk("mid_pkt_ready_async", 32'(pkt_ready), 32'd0);
        pay_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_active_low = 1'b1;
        @(posedge clk);
        #1;
        run_pkt(11, 4'h4, 12'd2, 0, -1);
        check_legal(11, 12'd2, 32'h20068600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
